// File: rtl/hamming_pkg.sv
// Shared constants, buffer state encoding and width helper for the Hamming
// result capture stage.
package hamming_pkg;

  localparam int CC_DEF     = 1600;
  localparam int W_DEF      = 11;
  localparam int THRESH_DEF = 800;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  // Smallest r with 2**r >= v; used for counter and distance widths.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/hamming_frame_counter.sv
// Counts consumed bits within a frame and flags the final bit of each frame.
module hamming_frame_counter
  import hamming_pkg::*;
#(
  parameter int CC = CC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_valid_i,
  output logic last_o
);

  localparam int CW = clog2(CC);
  localparam logic [CW-1:0] LAST_CNT = CW'(CC - 1);

  logic [CW-1:0] bit_cnt_q, bit_cnt_d;

  assign last_o = bit_valid_i && (bit_cnt_q == LAST_CNT);

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (bit_valid_i) bit_cnt_d = last_o ? '0 : bit_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) bit_cnt_q <= '0;
    else      bit_cnt_q <= bit_cnt_d;
  end

endmodule

// File: rtl/hamming_result_capture.sv
// Captures the accumulator distance on the last bit of each frame into a
// one-entry valid/ready buffer with threshold match and sticky drop flag.
module hamming_result_capture
  import hamming_pkg::*;
#(
  parameter int CC     = CC_DEF,
  parameter int W      = W_DEF,
  parameter int THRESH = THRESH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_valid,
  input  logic [W-1:0] acc_o,
  output logic         acc_clr,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_dist,
  output logic         res_match,
  output logic         overflow,
  output logic [15:0]  frame_cnt
);

  if (W != clog2(CC + 1)) begin : g_w_check
    $error("hamming_result_capture: W must equal clog2(CC+1)");
  end

  localparam logic [W-1:0] THR = W'(THRESH);

  logic       last;
  buf_state_e state_q, state_d;
  logic       load, drop;
  logic [W-1:0] dist_q, dist_d;
  logic       match_q, match_d;
  logic       ovf_q, ovf_d;
  logic [15:0] fcnt_q, fcnt_d;

  hamming_frame_counter #(.CC(CC)) u_frame_cnt (
    .clk        (clk),
    .rst        (rst),
    .bit_valid_i(bit_valid),
    .last_o     (last)
  );

  // Combinational so the accumulator clears on the same edge we capture.
  assign acc_clr = last || !rst;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= BUF_EMPTY;
      dist_q  <= '0;
      match_q <= 1'b0;
      ovf_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dist_q  <= dist_d;
      match_q <= match_d;
      ovf_q   <= ovf_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BUF_EMPTY: if (last) state_d = BUF_FULL;
      BUF_FULL:  if (res_ready && !last) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // A full buffer only takes a new result when it is popped the same cycle.
  always_comb begin
    load    = last && ((state_q == BUF_EMPTY) || res_ready);
    drop    = last && (state_q == BUF_FULL) && !res_ready;
    dist_d  = load ? acc_o : dist_q;
    match_d = load ? (acc_o <= THR) : match_q;
    ovf_d   = ovf_q || drop;
    fcnt_d  = fcnt_q + 16'(last);
  end

  assign res_valid = (state_q == BUF_FULL);
  assign res_dist  = dist_q;
  assign res_match = match_q;
  assign overflow  = ovf_q;
  assign frame_cnt = fcnt_q;

endmodule

// File: tb/tb_hamming_result_capture.sv
// Directed frame table plus randomized run against a frame-level model.
module tb_hamming_result_capture;

  localparam int CC = 16, W = 5, THRESH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         bit_valid = 1'b0;
  logic [W-1:0] acc_o = '0;
  logic         acc_clr, res_valid, res_match, overflow;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_dist;
  logic [15:0]  frame_cnt;

  always #5 clk = ~clk;

  hamming_result_capture #(.CC(CC), .W(W), .THRESH(THRESH)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .acc_o(acc_o),
    .acc_clr(acc_clr), .res_valid(res_valid), .res_ready(res_ready),
    .res_dist(res_dist), .res_match(res_match), .overflow(overflow),
    .frame_cnt(frame_cnt)
  );

  int n_pass = 0, n_total = 0;

  // Reference: position in frame plus the single buffered result.
  int m_cnt = 0, m_dist = 0, m_fcnt = 0;
  bit m_valid = 0, m_match = 0, m_ovf = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic cyc(input bit r, input bit v, input int acc, input bit rdy, output bit clr);
    bit mlast;
    rst = r; bit_valid = v; acc_o = W'(acc); res_ready = rdy;
    #1;
    mlast = r && v && (m_cnt == CC - 1);
    clr = acc_clr;
    chk("acc_clr", int'(acc_clr), int'((!r) || mlast));
    if (!r) begin
      m_cnt = 0; m_valid = 0; m_dist = 0; m_match = 0; m_ovf = 0; m_fcnt = 0;
    end else begin
      if (v) m_cnt = (m_cnt + 1) % CC;
      if (mlast) begin
        m_fcnt = (m_fcnt + 1) % 65536;
        if (m_valid && !rdy) m_ovf = 1;
        else begin m_valid = 1; m_dist = acc; m_match = (acc <= THRESH); end
      end else if (m_valid && rdy) m_valid = 0;
    end
    @(posedge clk); #1;
    chk("res_valid", int'(res_valid), int'(m_valid));
    chk("res_dist",  int'(res_dist),  m_dist);
    chk("res_match", int'(res_match), int'(m_match));
    chk("overflow",  int'(overflow),  int'(m_ovf));
    chk("frame_cnt", int'(frame_cnt), m_fcnt);
  endtask

  task automatic do_reset(input int n);
    bit c;
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, c);
  endtask

  // CC valid bits; ready low except possibly on the last bit.
  task automatic run_frame(input int acc_last, input bit rdy_last,
                           output int npulse, output bit on_last);
    bit c;
    npulse = 0; on_last = 0;
    for (int i = 0; i < CC; i++) begin
      if (i == CC - 1) cyc(1, 1, acc_last, rdy_last, c);
      else             cyc(1, 1, int'($urandom_range(0, 16)), 0, c);
      if (c) npulse++;
      if (i == CC - 1) on_last = c;
    end
  endtask

  typedef struct {
    bit rst_before;
    int acc_last;
    bit rdy_last;
    bit exp_valid;
    int exp_dist;
    bit exp_match;
    bit exp_ovf;
    int exp_fcnt;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit c;
    int np, idx;
    bit ol;

    vecs[0] = '{1, 3,  0, 1, 3,  1, 0, 1};
    vecs[1] = '{0, 9,  0, 1, 3,  1, 1, 2};
    vecs[2] = '{1, 2,  0, 1, 2,  1, 0, 1};
    vecs[3] = '{0, 16, 1, 1, 16, 0, 0, 2};

    @(posedge clk); #1;

    // Reset behaviour and release
    do_reset(3);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_ovf",   int'(overflow),  0);
    chk("rst_fcnt",  int'(frame_cnt), 0);
    rst = 1; bit_valid = 0; #1;
    chk("rel_clr", int'(acc_clr), 0);
    @(posedge clk); #1;

    for (int k = 0; k < 4; k++) begin
      if (vecs[k].rst_before) begin do_reset(2); cyc(1, 0, 0, 0, c); end
      run_frame(vecs[k].acc_last, vecs[k].rdy_last, np, ol);
      chk($sformatf("v%0d_clr_cnt", k), np, 1);
      chk($sformatf("v%0d_clr_last", k), int'(ol), 1);
      chk($sformatf("v%0d_valid", k), int'(res_valid), int'(vecs[k].exp_valid));
      chk($sformatf("v%0d_dist", k),  int'(res_dist),  vecs[k].exp_dist);
      chk($sformatf("v%0d_match", k), int'(res_match), int'(vecs[k].exp_match));
      chk($sformatf("v%0d_ovf", k),   int'(overflow),  int'(vecs[k].exp_ovf));
      chk($sformatf("v%0d_fcnt", k),  int'(frame_cnt), vecs[k].exp_fcnt);
      if (k == 1) begin
        cyc(1, 0, 0, 1, c);
        chk("pop_valid", int'(res_valid), 0);
        chk("pop_ovf",   int'(overflow),  1);
      end
    end

    // Gaps: 8 valid, 5 idle, 8 valid; one clear on the 16th valid bit only
    do_reset(2);
    np = 0; idx = -1;
    for (int i = 0; i < 21; i++) begin
      cyc(1, (i < 8 || i >= 13), 7, 0, c);
      if (c) begin np++; idx = i; end
    end
    chk("gap_clr_cnt", np, 1);
    chk("gap_clr_idx", idx, 20);
    chk("gap_dist", int'(res_dist), 7);
    chk("gap_fcnt", int'(frame_cnt), 1);

    // Reset mid-frame at bit_cnt=10
    for (int i = 0; i < 10; i++) cyc(1, 1, 3, 0, c);
    cyc(0, 1, 3, 0, c);
    chk("mid_valid", int'(res_valid), 0);
    chk("mid_fcnt",  int'(frame_cnt), 0);
    chk("mid_dist",  int'(res_dist),  0);
    run_frame(5, 0, np, ol);
    chk("mid_clr_cnt", np, 1);
    chk("mid_clr_last", int'(ol), 1);
    chk("mid_res", int'(res_dist), 5);

    // Randomized traffic against the model
    for (int i = 0; i < 1000; i++)
      cyc($urandom_range(0, 199) != 0, ($urandom % 4) != 0,
          int'($urandom_range(0, 16)), ($urandom % 3) == 0, c);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
